// File: rtl/eaf_bloom_filter_param.sv
// eaf_bloom_filter_param: eviction address Bloom filter with multi-cycle hashed probe/insert and auto-clear.
// Optional feature macro: EAF_DUP_SKIP_EN (inserts of already-present addresses do not count toward auto-clear).
module eaf_bloom_filter_param #(
   parameter int ADDR_W      = 32,
   parameter int OFFSET_BITS = 6,
   parameter int BF_BITS     = 1024,
   parameter int NUM_HASH    = 4,
   parameter int MAX_ENTRIES = 16,
   parameter int IDX_W       = $clog2(BF_BITS),
   parameter int CNT_W       = $clog2(MAX_ENTRIES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   output logic              resp_op,
   output logic              addr_exists,
   output logic              priority_level,
   output logic              clear_o,
   output logic [CNT_W-1:0]  insert_count
);
   localparam int HW  = NUM_HASH > 1 ? $clog2(NUM_HASH) : 1;
   localparam int NSL = (ADDR_W + IDX_W - 1) / IDX_W;
   localparam int PW  = NSL * IDX_W;

   typedef enum logic [1:0] {IDLE, PROBE, RESP, CLEAR} state_t;

   state_t             state, state_nx;
   logic [HW-1:0]      h;
   logic [ADDR_W-1:0]  addr_q;
   logic               op_q;
   logic               acc;
   logic               clr_pend;
   logic [BF_BITS-1:0] bits;
   logic [IDX_W-1:0]   idx;
   logic               hit;
   logic               last;
   logic               counted;

   function automatic logic [IDX_W-1:0] hash_idx(input logic [ADDR_W-1:0] a, input logic [HW-1:0] hh);
      logic [ADDR_W-1:0] t;
      logic [ADDR_W-1:0] r;
      logic [PW-1:0]     p;
      logic [IDX_W-1:0]  f;
      int                rot;
      t   = a >> OFFSET_BITS;
      rot = (4 * int'(hh) + 1) % ADDR_W;
      r   = (t << rot) | (t >> (ADDR_W - rot));
      p   = PW'(t ^ r);
      f   = '0;
      for (int s = 0; s < NSL; s++) f ^= IDX_W'(p >> (s * IDX_W));
      return f ^ IDX_W'(hh);
   endfunction

   // Probe index, running hit result and whether this insert counts toward auto-clear
   always_comb begin
      idx  = hash_idx(addr_q, h);
      hit  = acc & bits[idx];
      last = h == HW'(NUM_HASH - 1);
`ifdef EAF_DUP_SKIP_EN
      counted = op_q & ~hit;
`else
      counted = op_q;
`endif
   end

   // Next state and state-decoded handshake/pulse outputs
   always_comb begin
      state_nx   = state == IDLE  ? (req_valid ? PROBE : IDLE) :
                   state == PROBE ? (last ? RESP : PROBE) :
                   state == RESP  ? (clr_pend ? CLEAR : IDLE) : IDLE;
      req_ready  = state == IDLE;
      resp_valid = state == RESP;
      clear_o    = state == CLEAR;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Request latch, probe sequencing, filter bits, result registers and insert counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h              <= '0;
         addr_q         <= '0;
         op_q           <= 1'b0;
         acc            <= 1'b1;
         clr_pend       <= 1'b0;
         bits           <= '0;
         resp_op        <= 1'b0;
         addr_exists    <= 1'b0;
         priority_level <= 1'b0;
         insert_count   <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            addr_q <= req_addr;
            op_q   <= req_op;
            acc    <= 1'b1;
            h      <= '0;
         end
         if (state == PROBE) begin
            acc <= hit;
            h   <= h + HW'(1);
            if (op_q) bits[idx] <= 1'b1;
            if (last) begin
               addr_exists    <= hit;
               priority_level <= hit & ~op_q;
               resp_op        <= op_q;
               clr_pend       <= counted && (insert_count + CNT_W'(1) == CNT_W'(MAX_ENTRIES));
               if (counted) insert_count <= insert_count + CNT_W'(1);
            end
         end
         if (state == RESP && clr_pend) begin
            bits         <= '0;
            insert_count <= '0;
            clr_pend     <= 1'b0;
         end
      end
   end
endmodule

// File: doc/eaf_bloom_filter_param.md
# eaf_bloom_filter_param

Parametrised Eviction Address Filter: a Bloom filter of `BF_BITS` single-bit entries that records addresses evicted from the cache and classifies incoming miss addresses as recently evicted or new. Each request is accepted through a valid/ready handshake and probed with `NUM_HASH` hash functions, one per cycle. The filter clears itself once `MAX_ENTRIES` inserts have accumulated. It sits between the cache controller (eviction and miss paths) and the replacement logic, which uses `priority_level` to pick MRU or LRU insertion.

## Interface
- `ADDR_W`, 32, request address width
- `OFFSET_BITS`, 6, line-offset bits dropped before hashing
- `BF_BITS`, 1024, filter size; power of two, ≥ 2
- `NUM_HASH`, 4, hash functions per request, 1..8
- `MAX_ENTRIES`, 16, inserts before auto-clear (cache line count)
- `IDX_W`, `$clog2(BF_BITS)`, derived; not to be overridden
- `CNT_W`, `$clog2(MAX_ENTRIES+1)`, derived
- `clk  in  1  clock`, rising-edge
- `rst  in  1  reset`, asynchronous, active-low
- `req_valid  in  1  request present`
- `req_ready  out  1  block can accept`; high only in IDLE
- `req_op  in  1  0=test, 1=insert`
- `req_addr  in  ADDR_W  address`
- `resp_valid  out  1  one-cycle result pulse`
- `resp_op  out  1  op of the completed request`
- `addr_exists  out  1  all probed bits were set`
- `priority_level  out  1  1=MRU insert, 0=LRU`; equals `addr_exists` for tests, 0 for inserts
- `clear_o  out  1  one-cycle pulse when the filter is flash-cleared`
- `insert_count  out  CNT_W  inserts since last clear`

## Operation
- States:
  - IDLE: `req_ready`=1.
  - PROBE: `NUM_HASH` cycles; hash counter h = 0..NUM_HASH-1.
  - RESP: 1 cycle.
  - CLEAR: 1 cycle.
- Transitions:
  - IDLE→PROBE on `req_valid && req_ready`; `req_addr` and `req_op` are latched.
  - PROBE→RESP after h = NUM_HASH-1.
  - RESP→CLEAR if op = insert and the updated `insert_count` == MAX_ENTRIES; otherwise RESP→IDLE.
  - CLEAR→IDLE.
- Hashing:
  - t = latched addr >> OFFSET_BITS, zero-extended to ADDR_W.
  - r_h = t rotated left by (4h+1) mod ADDR_W.
  - idx_h = XOR-fold of (t ^ r_h) into IDX_W-bit slices (last slice zero-padded), XOR h.
- PROBE, each cycle:
  - hit accumulator &= bit[idx_h]; accumulator initialised to 1.
  - If insert: bit[idx_h] ← 1.
  - A later probe of the same request sees bits set by earlier probes of that request.
- RESP:
  - `resp_valid`=1; `addr_exists` = accumulator; `resp_op` = latched op.
  - An insert increments `insert_count` in this cycle.
- CLEAR: all bits ← 0; `insert_count` ← 0; `clear_o`=1.
- Requests are never dropped. `req_valid` while `req_ready`=0 is held off by the requester. `req_addr` changes after acceptance are ignored.
- `resp_valid` cannot be backpressured.

## Timing
- Reset: state IDLE, all bits 0, all outputs 0 except `req_ready`=1.
- Reset mid-request:
  - The request is abandoned and no `resp_valid` is issued.
  - The filter is empty after reset.
- Latency: `resp_valid` is high in the cycle NUM_HASH+1 cycles after the accepting edge.
- Throughput:
  - One request per NUM_HASH+2 cycles.
  - NUM_HASH+3 cycles when the request triggers a clear.
- `addr_exists`, `priority_level` and `resp_op` are valid only while `resp_valid`=1; they hold their last value otherwise.
- `insert_count` is registered and saturation is impossible, because CLEAR fires at MAX_ENTRIES.

## Configuration
- `EAF_DUP_SKIP_EN` defined:
  - An insert whose accumulator is 1 (address already present) does not increment `insert_count` and cannot trigger CLEAR.
  - Bits are still written.
- Not defined: every insert increments `insert_count`.

## Test plan
- Reset, then test addr 0x0000_1040 → `resp_valid` 5 cycles after accept (NUM_HASH=4), `addr_exists`=0, `priority_level`=0.
- Insert 0x0000_1040, then test 0x0000_1040 → insert response has `resp_op`=1, `insert_count`=1; test returns `addr_exists`=1, `priority_level`=1.
- Test 0x0000_1044 (same line as 0x1040) after the insert → `addr_exists`=1, because offset bits are ignored.
- 16 inserts of distinct lines 0x0, 0x40, … 0x3C0:
  - The 16th response is followed by `clear_o`=1 for one cycle, `req_ready` low for that cycle, and `insert_count`=0.
  - A following test of 0x0 → `addr_exists`=0.
- Insert 0x80 twice:
  - With `EAF_DUP_SKIP_EN`: `insert_count`=1.
  - Without: `insert_count`=2.
- Assert `rst` during PROBE of an insert → no `resp_valid`; outputs at reset values; a subsequent test of that address → `addr_exists`=0.
